// File: rtl/capture_if.sv
// capture_if: bundles the configuration, front-end status and buffer-side
// signals of the ADC capture controller.
//   master : config/status source (register block, front end, MCU flag)
//   slave  : the capture controller
// Signals:
//   cfg_div      sample period minus one, in clk cycles
//   cfg_mode     00 stop, 01 single, 10 normal, 11 auto
//   cfg_edge     0 rising, 1 falling trigger
//   cfg_holdoff  sample ticks to wait after a swap before re-arming
//   arm          one-cycle pulse, starts a capture in single mode
//   stable       front end settled; low aborts the current capture
//   trig_in      comparator output, already in the clk domain
//   rd_busy      MCU readout of the idle bank in progress
//   sample_en    one-cycle buffer write strobe
//   wr_addr      buffer write address, valid with sample_en
//   wr_bank      bank being written; the MCU reads the other one
//   frame_ready  a completed frame sits in ~wr_bank
//   frame_count  completed-frame counter, wraps
//   state_o      controller state (0 IDLE .. 4 HOLDOFF)
interface capture_if #(
    parameter int DIV_W  = 16,
    parameter int HOLD_W = 16,
    parameter int AW     = 10
);
    logic [DIV_W-1:0]  cfg_div;
    logic [1:0]        cfg_mode;
    logic              cfg_edge;
    logic [HOLD_W-1:0] cfg_holdoff;
    logic              arm;
    logic              stable;
    logic              trig_in;
    logic              rd_busy;
    logic              sample_en;
    logic [AW-1:0]     wr_addr;
    logic              wr_bank;
    logic              frame_ready;
    logic [7:0]        frame_count;
    logic [2:0]        state_o;

    modport master (
        output cfg_div, cfg_mode, cfg_edge, cfg_holdoff, arm, stable, trig_in, rd_busy,
        input  sample_en, wr_addr, wr_bank, frame_ready, frame_count, state_o
    );

    modport slave (
        input  cfg_div, cfg_mode, cfg_edge, cfg_holdoff, arm, stable, trig_in, rd_busy,
        output sample_en, wr_addr, wr_bank, frame_ready, frame_count, state_o
    );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequencing controller for the dual-bank ADC capture buffer.
// Generates the decimated sample strobe, detects the trigger (edge select,
// auto trigger, holdoff), drives the buffer write address and bank select,
// and swaps banks once the MCU is not reading.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  capture_if.slave (config/status in, buffer write side out)
module capture_ctrl #(
    parameter  int DEPTH      = 1024,
    parameter  int DIV_W      = 16,
    parameter  int HOLD_W     = 16,
    parameter  int AUTO_TICKS = 4096,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst,
    capture_if.slave bus
);
    localparam int AUTO_W = $clog2(AUTO_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_CAPTURE = 3'd2,
        S_SWAP    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [DIV_W-1:0]  r_div_per;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [AUTO_W-1:0] r_auto_cnt;
    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     r_wr_addr;
    logic              r_sample_en;
    logic              r_wr_bank;
    logic              r_frame_ready;
    logic [7:0]        r_frame_count;
    logic              r_busy_d;
    logic              r_trig_last;

    logic w_tick;
    logic w_single;
    logic w_auto;
    logic w_run_mode;
    logic w_abort;
    logic w_edge;
    logic w_auto_fire;
    logic w_hold_done;
    logic w_sample;
    logic w_swap;

    // r_div_per holds the period in force, so a cfg_div change only lands at a reload
    assign w_tick     = (r_state != S_IDLE) && (r_div_cnt == r_div_per);
    assign w_single   = (bus.cfg_mode == 2'b01);
    assign w_auto     = (bus.cfg_mode == 2'b11);
    assign w_run_mode = bus.cfg_mode[1];
    assign w_abort    = (bus.cfg_mode == 2'b00) || !bus.stable;

    // edge = sampled level changed and now sits at the selected polarity
    assign w_edge      = w_tick && (bus.trig_in != r_trig_last) && (bus.trig_in != bus.cfg_edge);
    assign w_auto_fire = w_tick && w_auto && (r_auto_cnt == AUTO_W'(AUTO_TICKS - 1));
    // the >= term also covers cfg_holdoff=0 and a holdoff lowered mid-count
    assign w_hold_done = (r_hold_cnt >= bus.cfg_holdoff) ||
                         (w_tick && (r_hold_cnt == bus.cfg_holdoff - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_sample = 1'b0;
        w_swap   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.stable && ((w_single && bus.arm) || w_run_mode)) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_abort)                         w_next = S_IDLE;
                else if (w_edge || w_auto_fire)      w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_tick) begin
                    w_sample = 1'b1;
                    if (&r_addr) w_next = S_SWAP;
                end
            end
            S_SWAP: begin
                // completes regardless of mode/stable so bank and flag stay paired
                if (!bus.rd_busy) begin
                    w_swap = 1'b1;
                    w_next = w_run_mode ? S_HOLDOFF : S_IDLE;
                end
            end
            S_HOLDOFF: begin
                if (w_abort)          w_next = S_IDLE;
                else if (w_hold_done) w_next = S_WAIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_div_per     <= '0;
            r_hold_cnt    <= '0;
            r_auto_cnt    <= '0;
            r_addr        <= '0;
            r_wr_addr     <= '0;
            r_sample_en   <= 1'b0;
            r_wr_bank     <= 1'b0;
            r_frame_ready <= 1'b0;
            r_frame_count <= '0;
            r_busy_d      <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_tick) begin
                r_div_cnt <= '0;
                r_div_per <= bus.cfg_div;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            // saturates so a long wait in normal mode cannot wrap
            if (r_state != S_WAIT)
                r_auto_cnt <= '0;
            else if (w_tick && (r_auto_cnt != AUTO_W'(AUTO_TICKS - 1)))
                r_auto_cnt <= r_auto_cnt + 1'b1;

            if (r_state != S_HOLDOFF) r_hold_cnt <= '0;
            else if (w_tick)          r_hold_cnt <= r_hold_cnt + 1'b1;

            if (r_state == S_WAIT) r_addr <= '0;
            else if (w_sample)     r_addr <= r_addr + 1'b1;

            r_sample_en <= w_sample;
            if (w_sample) r_wr_addr <= r_addr;

            r_busy_d <= bus.rd_busy;
            if (w_swap) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_ready <= 1'b1;
                r_frame_count <= r_frame_count + 1'b1;
            end else if (bus.rd_busy && !r_busy_d) begin
                r_frame_ready <= 1'b0;
            end
        end
    end

    // reloaded on WAIT entry so a level already present is not seen as an edge
    always_ff @(posedge clk) begin
        if (r_state != S_WAIT && w_next == S_WAIT) r_trig_last <= bus.trig_in;
        else if (w_tick)                           r_trig_last <= bus.trig_in;
    end

    assign bus.sample_en   = r_sample_en;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_bank     = r_wr_bank;
    assign bus.frame_ready = r_frame_ready;
    assign bus.frame_count = r_frame_count;
    assign bus.state_o     = r_state;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: scoreboard bench for capture_ctrl (DEPTH=16, AUTO_TICKS=8).
// Expected write addresses are queued when a capture is provoked and popped
// by a monitor on every sample_en; state/bank/flag/counter values are
// compared against a small bench-side model.
module tb_capture_ctrl;
    localparam int DEPTH      = 16;
    localparam int DIV_W      = 16;
    localparam int HOLD_W     = 16;
    localparam int AUTO_TICKS = 8;
    localparam int AW         = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_CAPT = 3'd2;
    localparam logic [2:0] ST_SWAP = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    capture_if #(.DIV_W(DIV_W), .HOLD_W(HOLD_W), .AW(AW)) bus ();

    capture_ctrl #(
        .DEPTH(DEPTH), .DIV_W(DIV_W), .HOLD_W(HOLD_W), .AUTO_TICKS(AUTO_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         n_chk    = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         last_cyc = 0;
    int         exp_q[$];
    logic [7:0] exp_cnt  = 8'd0;
    logic       exp_bank = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (bus.state_o != s && n < budget) begin
            step(1);
            n++;
        end
        check(tag, bus.state_o, s);
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(i);
    endtask

    task automatic go_idle();
        bus.cfg_mode = 2'b00;
        wait_state(ST_IDLE, 10, "go_idle");
    endtask

    // waits for SWAP (rd_busy low), then checks the swap result one cycle later
    task automatic expect_swap(input string tag, input logic [2:0] after_st, input bit stop_after);
        wait_state(ST_SWAP, 400, {tag, "_swap"});
        if (stop_after) bus.cfg_mode = 2'b00;
        exp_cnt  = exp_cnt + 8'd1;
        exp_bank = ~exp_bank;
        step(1);
        check({tag, "_bank"}, bus.wr_bank, exp_bank);
        check({tag, "_cnt"}, bus.frame_count, exp_cnt);
        check({tag, "_rdy"}, bus.frame_ready, 1);
        check({tag, "_st"}, bus.state_o, after_st);
        check({tag, "_q"}, exp_q.size(), 0);
    endtask

    task automatic single_frame(input string tag);
        bus.trig_in = 1'b0;
        bus.arm     = 1'b1;
        step(1);
        bus.arm = 1'b0;
        check({tag, "_arm"}, bus.state_o, ST_WAIT);
        push_frame(DEPTH);
        bus.trig_in = 1'b1;
        expect_swap(tag, ST_IDLE, 1'b0);
    endtask

    // scoreboard monitor: every strobe must match the next queued address
    always begin
        @(posedge clk);
        #1;
        if (bus.sample_en) begin
            if (exp_q.size() == 0) begin
                check("unexp_sample", bus.sample_en, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("wr_addr", bus.wr_addr, e);
                if (e != 0) check("se_gap", cyc - last_cyc, int'(bus.cfg_div) + 1);
            end
            last_cyc = cyc;
        end
    end

    initial begin
        int  n;
        int  bad;
        bit  found;

        bus.cfg_div     = 16'd3;
        bus.cfg_mode    = 2'b00;
        bus.cfg_edge    = 1'b0;
        bus.cfg_holdoff = 16'd0;
        bus.arm         = 1'b0;
        bus.stable      = 1'b0;
        bus.trig_in     = 1'b0;
        bus.rd_busy     = 1'b0;

        step(3);
        check("rst_state", bus.state_o, ST_IDLE);
        check("rst_se", bus.sample_en, 0);
        check("rst_addr", bus.wr_addr, 0);
        check("rst_bank", bus.wr_bank, 0);
        check("rst_rdy", bus.frame_ready, 0);
        check("rst_cnt", bus.frame_count, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1);

        // normal mode, rising edge, cfg_div=3
        bus.cfg_mode = 2'b10;
        bus.stable   = 1'b1;
        wait_state(ST_WAIT, 5, "norm_wait");
        step(10);
        push_frame(DEPTH);
        bus.trig_in = 1'b1;
        expect_swap("norm", ST_HOLD, 1'b0);
        step(1);
        check("hold0_wait", bus.state_o, ST_WAIT);

        // rd_busy rise clears frame_ready one cycle later
        bus.rd_busy = 1'b1;
        step(1);
        check("busy_clr_rdy", bus.frame_ready, 0);

        // swap stalls while rd_busy is held
        bus.trig_in = 1'b0;
        step(10);
        push_frame(DEPTH);
        bus.trig_in = 1'b1;
        wait_state(ST_SWAP, 400, "busy_swap");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (bus.state_o != ST_SWAP || bus.wr_bank != exp_bank) bad++;
        end
        check("busy_hold", bad, 0);
        check("busy_rdy", bus.frame_ready, 0);
        bus.rd_busy = 1'b0;
        exp_cnt  = exp_cnt + 8'd1;
        exp_bank = ~exp_bank;
        step(1);
        check("rel_bank", bus.wr_bank, exp_bank);
        check("rel_cnt", bus.frame_count, exp_cnt);
        check("rel_rdy", bus.frame_ready, 1);
        check("rel_st", bus.state_o, ST_HOLD);
        go_idle();

        // auto mode, trig_in low: capture forced after AUTO_TICKS ticks
        bus.trig_in  = 1'b0;
        bus.cfg_mode = 2'b11;
        push_frame(DEPTH);
        wait_state(ST_WAIT, 5, "auto_wait");
        n = 0;
        while (bus.state_o != ST_CAPT && n < 200) begin
            step(1);
            n++;
        end
        check("auto_lat", n, AUTO_TICKS * 4);
        expect_swap("auto", ST_IDLE, 1'b1);

        // falling edge with cfg_edge=1
        bus.cfg_edge = 1'b1;
        bus.trig_in  = 1'b1;
        bus.cfg_mode = 2'b10;
        wait_state(ST_WAIT, 5, "fall_wait");
        step(10);
        push_frame(DEPTH);
        bus.trig_in = 1'b0;
        expect_swap("fall", ST_IDLE, 1'b1);

        // rising edge with cfg_edge=1: no capture
        bus.cfg_mode = 2'b10;
        wait_state(ST_WAIT, 5, "rise1_wait");
        step(10);
        bus.trig_in = 1'b1;
        step(40);
        check("rise1_nocap", bus.state_o, ST_WAIT);
        go_idle();
        bus.cfg_edge = 1'b0;

        // stable dropped after address 7
        bus.trig_in  = 1'b0;
        bus.cfg_mode = 2'b10;
        wait_state(ST_WAIT, 5, "drop_wait");
        step(10);
        push_frame(8);
        bus.trig_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (bus.sample_en && bus.wr_addr == 4'd7) found = 1'b1;
        end
        check("drop_seen7", found, 1);
        bus.stable = 1'b0;
        step(1);
        check("drop_idle", bus.state_o, ST_IDLE);
        check("drop_bank", bus.wr_bank, exp_bank);
        check("drop_cnt", bus.frame_count, exp_cnt);
        step(12);
        check("drop_q", exp_q.size(), 0);
        bus.trig_in = 1'b0;
        bus.stable  = 1'b1;
        wait_state(ST_WAIT, 5, "restart_wait");
        step(10);
        push_frame(DEPTH);
        bus.trig_in = 1'b1;
        expect_swap("restart", ST_IDLE, 1'b1);

        // single mode: nothing without arm, then one frame per arm
        bus.trig_in  = 1'b0;
        bus.cfg_mode = 2'b01;
        step(20);
        check("single_noarm", bus.state_o, ST_IDLE);
        single_frame("single1");
        bus.cfg_div = 16'd0;
        n = 0;
        while (exp_cnt != 8'd255 && n < 300) begin
            single_frame("singleN");
            n++;
        end
        check("pre_wrap_cnt", bus.frame_count, 255);
        single_frame("wrap");
        check("wrap_cnt", bus.frame_count, 0);
        go_idle();

        // holdoff=5 at cfg_div=0; trigger toggles during holdoff are ignored
        bus.cfg_holdoff = 16'd5;
        bus.trig_in     = 1'b0;
        bus.cfg_mode    = 2'b10;
        wait_state(ST_WAIT, 5, "ho_wait");
        push_frame(DEPTH);
        bus.trig_in = 1'b1;
        expect_swap("ho", ST_HOLD, 1'b0);
        bus.trig_in = 1'b0;
        n = 0;
        while (bus.state_o != ST_WAIT && n < 50) begin
            step(1);
            n++;
            if (n == 2) bus.trig_in = 1'b1;
        end
        check("ho_len", n, 5);
        step(10);
        check("ho_noedge", bus.state_o, ST_WAIT);

        // asynchronous reset in the middle of a capture
        bus.cfg_div     = 16'd3;
        bus.cfg_holdoff = 16'd0;
        bus.trig_in     = 1'b0;
        step(10);
        push_frame(3);
        bus.trig_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (bus.sample_en && bus.wr_addr == 4'd2) found = 1'b1;
        end
        check("rstmid_seen2", found, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_state", bus.state_o, ST_IDLE);
        check("rstmid_se", bus.sample_en, 0);
        check("rstmid_addr", bus.wr_addr, 0);
        check("rstmid_bank", bus.wr_bank, 0);
        check("rstmid_rdy", bus.frame_ready, 0);
        check("rstmid_cnt", bus.frame_count, 0);
        step(2);
        @(negedge clk);
        rst = 1'b0;
        step(5);
        check("final_q", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Sequencing controller for the ADC dual-buffer capture path. It generates the decimated sample strobe and runs trigger detection (edge select, auto-trigger, holdoff). It produces write address and bank select for the two sample buffers and handles the bank swap against the MCU read-busy flag. It sits between the config registers written over FSMC and the buffer RAMs, and replaces ad-hoc sampling logic inside the buffer.

## Interface
- DEPTH, 1024: samples per frame (power of two); AW = $clog2(DEPTH)
- DIV_W, 16: width of sample divider
- HOLD_W, 16: width of holdoff counter
- AUTO_TICKS, 4096: sample ticks without a trigger before auto mode forces capture
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- cfg_div  in  DIV_W  sample period = cfg_div+1 clk cycles
- cfg_mode  in  2  00 stop, 01 single, 10 normal, 11 auto
- cfg_edge  in  1  0 rising, 1 falling trigger
- cfg_holdoff  in  HOLD_W  sample ticks to wait after a swap before re-arming
- arm  in  1  one-cycle pulse; starts one capture in single mode
- stable  in  1  ADC/front-end stable; low aborts capture
- trig_in  in  1  comparator output, already synchronized to clk
- rd_busy  in  1  MCU readout in progress (level)
- sample_en  out  1  registered one-cycle write strobe to the buffer
- wr_addr  out  AW  buffer write address, valid with sample_en
- wr_bank  out  1  bank being written; MCU reads ~wr_bank
- frame_ready  out  1  completed frame available in ~wr_bank
- frame_count  out  8  completed-frame counter, wraps 255->0
- state_o  out  3  current state: 0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 SWAP, 4 HOLDOFF

## Operation
- Divider: counter runs in every state except IDLE and is cleared in IDLE. A tick occurs when count==cfg_div, then the counter reloads 0. With cfg_div=0 a tick occurs every cycle. A cfg_div change takes effect at the next reload.
- Trigger sampling: trig_in is captured only on ticks (prev/current pair updated per tick). An edge is current!=prev matching cfg_edge. Prev is reloaded with trig_in on entry to WAIT_TRIG, so a level present on entry is not an edge.
- IDLE: with stop mode, stay. With single mode, go to WAIT_TRIG on arm & stable. With normal or auto mode, go to WAIT_TRIG when stable.
- WAIT_TRIG: on an edge, go to CAPTURE with the address cleared. In auto mode, AUTO_TICKS ticks without an edge force CAPTURE. The auto counter clears on state entry.
- CAPTURE: each tick asserts sample_en with the current wr_addr, then increments the address. The write at address DEPTH-1 moves the state to SWAP.
- SWAP: wait while rd_busy=1. When rd_busy=0: toggle wr_bank, set frame_ready, increment frame_count. Then go to IDLE in single mode, otherwise to HOLDOFF.
- HOLDOFF: count cfg_holdoff ticks, then go to WAIT_TRIG. cfg_holdoff=0 goes to WAIT_TRIG on the next cycle.
- frame_ready clears on the rd_busy rising edge. Clear and set cannot coincide, because a swap needs rd_busy=0.
- stable low in WAIT_TRIG, CAPTURE or HOLDOFF: go to IDLE next cycle. The partial frame is discarded: no swap, wr_bank unchanged, no sample_en.
- cfg_mode=00 forces IDLE from any state except SWAP. SWAP always completes first so that bank and flag stay consistent.
- arm outside IDLE, or arm in non-single mode: ignored.
- Reset: state IDLE, sample_en 0, wr_addr 0, wr_bank 0, frame_ready 0, frame_count 0, divider/holdoff/auto counters 0.

## Timing
- All outputs are registered; state_o reflects the current state register.
- Trigger edge detected on tick k: first sample_en (addr 0) on tick k+1, i.e. cfg_div+1 cycles after the trigger tick.
- sample_en pulses are exactly cfg_div+1 cycles apart within a frame. A frame is DEPTH pulses, addresses 0..DEPTH-1 in order, with no gaps or repeats.
- Last sample_en (addr DEPTH-1) to SWAP: next cycle. SWAP with rd_busy=0: wr_bank and frame_ready update 1 cycle after SWAP entry.
- rd_busy rise: frame_ready low on the following cycle.
- Async reset takes effect immediately. Deassertion is synchronous to clk by an external synchronizer.

## Test plan
- Normal mode, cfg_div=3, cfg_edge=0, DEPTH=16, rising trig_in: 16 sample_en pulses 4 cycles apart at addr 0..15; then wr_bank 0->1, frame_ready=1, frame_count=1.
- Auto mode, AUTO_TICKS=8, trig_in held 0: capture starts after 8 ticks. Falling edge with cfg_edge=1 in normal mode: capture starts. Rising edge with cfg_edge=1: no capture.
- rd_busy=1 held during SWAP for 50 cycles: state_o=3 throughout, wr_bank unchanged. Release: swap next cycle. rd_busy rise then clears frame_ready in 1 cycle.
- stable dropped at addr 7: IDLE next cycle, wr_bank and frame_count unchanged. stable restored: new frame restarts at addr 0.
- Single mode: no activity without arm. arm + edge gives one frame, then IDLE. A second arm gives a second frame; frame_count goes 255->0 on wrap.
- cfg_holdoff=5, cfg_div=0: WAIT_TRIG re-entered 5 cycles after HOLDOFF entry. Edges during holdoff are ignored. rst asserted mid-CAPTURE: all outputs return to reset values immediately.
